// File: rtl/hsv_pkg.sv
// hsv_pkg: shared HSV colour constants, pixel type and hue-sector helpers
package hsv_pkg;

    localparam int SECTOR_W = 3;

    localparam logic [7:0] SECT_B1   = 8'd43;
    localparam logic [7:0] SECT_B2   = 8'd86;
    localparam logic [7:0] SECT_B3   = 8'd129;
    localparam logic [7:0] SECT_B4   = 8'd172;
    localparam logic [7:0] SECT_B5   = 8'd215;
    localparam logic [7:0] HUE_THIRD = 8'd85;

    typedef logic [SECTOR_W-1:0] sector_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    // h/43 without a divider: compare against the five sector starts
    function automatic sector_t hue_sector(input logic [7:0] h);
        return (h >= SECT_B5) ? 3'd5 :
               (h >= SECT_B4) ? 3'd4 :
               (h >= SECT_B3) ? 3'd3 :
               (h >= SECT_B2) ? 3'd2 :
               (h >= SECT_B1) ? 3'd1 : 3'd0;
    endfunction

    // First hue of a sector, i.e. 43*sector
    function automatic logic [7:0] sector_base(input sector_t sec);
        return (sec == 3'd5) ? SECT_B5 :
               (sec == 3'd4) ? SECT_B4 :
               (sec == 3'd3) ? SECT_B3 :
               (sec == 3'd2) ? SECT_B2 :
               (sec == 3'd1) ? SECT_B1 : 8'd0;
    endfunction

    // Route v/p/q/t onto r,g,b by sector; gray pixels bypass the mux so r=g=b=v exactly
    function automatic pix_t sector_mux(input sector_t sec, input logic gray,
                                        input logic [7:0] v, input logic [7:0] p,
                                        input logic [7:0] q, input logic [7:0] t);
        return gray          ? {v, v, v} :
               (sec == 3'd0) ? {v, t, p} :
               (sec == 3'd1) ? {q, v, p} :
               (sec == 3'd2) ? {p, v, t} :
               (sec == 3'd3) ? {p, q, v} :
               (sec == 3'd4) ? {t, p, v} : {v, p, q};
    endfunction

endpackage

// File: rtl/hsv2rgb_if.sv
// hsv2rgb_if: valid/ready HSV input stream and RGB output stream of the converter
interface hsv2rgb_if;

    logic [7:0] h;
    logic [7:0] s;
    logic [7:0] v;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output h, s, v, in_valid, out_ready,
        input  in_ready, r, g, b, out_valid
    );

    modport slave (
        input  h, s, v, in_valid, out_ready,
        output in_ready, r, g, b, out_valid
    );

endinterface

// File: rtl/hsv2rgb_mul8x8_hi.sv
// mul8x8_hi: registered 8x8 multiply keeping only the upper product byte
module mul8x8_hi (
    input  logic       clock,
    input  logic       en,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    // Product register advances with the pipe and holds on stall
    always_ff @(posedge clock) begin
        if (en)
            p <= 8'(({8'd0, a} * {8'd0, b}) >> 8);
    end

endmodule

// File: rtl/hsv2rgb.sv
// hsv2rgb: pipelined HSV to RGB converter; define HSV2RGB_SKID_EN for a 2-entry output skid buffer
module hsv2rgb
    import hsv_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    hsv2rgb_if.slave bus
);

    logic       advance;
    logic       accept;
    logic [7:0] h1, s1, v1, f1;
    sector_t    sec1, sec2, sec3;
    logic [7:0] v2, p2, sf2, sfi2;
    logic [7:0] v3, p3, q3, t3;
    logic       gray2, gray3;
    logic       vld1, vld2, vld3, vld4, vld5;
    pix_t       pix4, pix5;

    assign accept = bus.in_valid && bus.in_ready;
    assign sec1   = hue_sector(h1);
    assign f1     = (h1 - sector_base(sec1)) * 8'd6;

    mul8x8_hi u_p   (.clock(clock), .en(advance), .a(v1), .b(8'd255 - s1),   .p(p2));
    mul8x8_hi u_sf  (.clock(clock), .en(advance), .a(s1), .b(f1),            .p(sf2));
    mul8x8_hi u_sfi (.clock(clock), .en(advance), .a(s1), .b(8'd255 - f1),   .p(sfi2));
    mul8x8_hi u_q   (.clock(clock), .en(advance), .a(v2), .b(8'd255 - sf2),  .p(q3));
    mul8x8_hi u_t   (.clock(clock), .en(advance), .a(v2), .b(8'd255 - sfi2), .p(t3));

    // Payload registers; valid bits qualify them so they need no reset
    always_ff @(posedge clock) begin
        if (advance) begin
            h1    <= bus.h;
            s1    <= bus.s;
            v1    <= bus.v;
            sec2  <= sec1;
            v2    <= v1;
            gray2 <= (s1 == 8'd0);
            sec3  <= sec2;
            v3    <= v2;
            p3    <= p2;
            gray3 <= gray2;
            pix4  <= sector_mux(sec3, gray3, v3, p3, q3, t3);
        end
    end

    // Valid bits travel with their data so bubbles keep their slot; output register clears on reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            vld1 <= 1'b0;
            vld2 <= 1'b0;
            vld3 <= 1'b0;
            vld4 <= 1'b0;
            vld5 <= 1'b0;
            pix5 <= '0;
        end else if (advance) begin
            vld1 <= accept;
            vld2 <= vld1;
            vld3 <= vld2;
            vld4 <= vld3;
            vld5 <= vld4;
            pix5 <= pix4;
        end
    end

`ifdef HSV2RGB_SKID_EN
    logic [1:0] cnt, cnt_nx;
    logic       rd, wr, push, pop, rdy;
    pix_t       skid [2];

    assign pop     = (cnt != 2'd0) && bus.out_ready;
    assign advance = !vld5 || (cnt != 2'd2) || pop;
    assign push    = advance && vld5;
    assign cnt_nx  = cnt + {1'b0, push} - {1'b0, pop};

    // Two-entry skid FIFO; in_ready is a flop so it never sees out_ready combinationally
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt     <= 2'd0;
            rd      <= 1'b0;
            wr      <= 1'b0;
            rdy     <= 1'b1;
            skid[0] <= '0;
            skid[1] <= '0;
        end else begin
            if (push)
                skid[wr] <= pix5;
            wr  <= wr ^ push;
            rd  <= rd ^ pop;
            cnt <= cnt_nx;
            rdy <= (cnt_nx <= 2'd1);
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = (cnt != 2'd0);
    assign bus.r         = skid[rd].r;
    assign bus.g         = skid[rd].g;
    assign bus.b         = skid[rd].b;
`else
    assign advance       = !vld5 || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = vld5;
    assign bus.r         = pix5.r;
    assign bus.g         = pix5.g;
    assign bus.b         = pix5.b;
`endif

endmodule

// File: doc/hsv2rgb.md
# hsv2rgb

Pipelined HSV-to-RGB converter: the inverse of the camera-path `rgb2hsv` block, using the same 8-bit encoding (hue 0–255 around the full circle, 85 ≈ 120°). It sits on the display/overlay side and turns HSV colour targets (dance-pose markers, hue-threshold previews) back into 8-bit RGB for the VGA pixel path. It has a valid/ready stream interface on both sides and supports backpressure.

## Interface
- `LATENCY`, 4: pipeline depth from input accept to `out_valid`. Fixed; documentation only, not tunable.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `h`, `s`, `v`  in  8 each  hue, saturation and value, sampled on accept.
- `in_valid`  in  1  an input triple is present.
- `in_ready`  out  1  block can accept; transfer happens when `in_valid && in_ready`.
- `r`, `g`, `b`  out  8 each  RGB result; stable while `out_valid && !out_ready`.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts; transfer happens when `out_valid && out_ready`.

## Operation
- Stage 1:
  - Latch `h`, `s`, `v`.
  - `sector = h/43` by constant compares at 43, 86, 129, 172, 215, giving 0–5.
  - `rem = h − 43·sector` (0–42); `f = 6·rem` (0–252, 8 bit).
- Stage 2:
  - `p = (v·(255−s))>>8`.
  - `sf = (s·f)>>8`.
  - `sfi = (s·(255−f))>>8`.
  - All products are 16 bit; take the upper byte.
- Stage 3:
  - `q = (v·(255−sf))>>8`.
  - `t = (v·(255−sfi))>>8`.
  - Carry `p`, `v`, `sector` and the gray flag (`s==0`) forward.
- Stage 4, sector mux to (r,g,b):
  - 0 → (v,t,p); 1 → (q,v,p); 2 → (p,v,t).
  - 3 → (p,q,v); 4 → (t,p,v); 5 → (v,p,q).
  - Gray flag set: r=g=b=v exactly, whatever the sector.
- Each stage has a valid bit. The whole pipe advances as one unit on `advance = !out_valid || out_ready`.
- `in_ready = advance` without the skid option.
- Bubbles travel with the data; there is no bubble collapsing, so ordering is strictly FIFO.

## Timing
- Reset (`reset==0` at an edge):
  - All stage valid bits clear; `out_valid`=0.
  - `r`, `g`, `b` = 0.
  - `in_ready` = 1 on the first cycle after reset release.
- Reset mid-stream discards all in-flight data. No partial result is emitted.
- Latency: data accepted at edge N appears with `out_valid`=1 after edge N+4, provided `advance` held throughout.
- Throughput: one result per clock while `out_ready`=1.
- Stall (`out_valid && !out_ready`):
  - All stage registers hold.
  - `r`, `g`, `b` and `out_valid` do not change.
  - `in_ready`=0, without the skid option.
- Accept and emit on the same edge is allowed and required for full throughput.
- `in_valid` low while advancing inserts a bubble; `out_valid` drops for exactly that slot.

## Configuration
- `HSV2RGB_SKID_EN` defined:
  - Adds a 2-entry output skid buffer after stage 4.
  - `in_ready` becomes a registered signal: high while the skid holds ≤1 entry. It has no combinational path from `out_ready`.
  - The pipe advances when the skid will have space.
  - Latency becomes 5.
  - Throughput is still 1/clock.
  - No data loss when `out_ready` drops with the pipe full.
- Not defined: behaviour exactly as in Operation. `in_ready` is combinational from `out_ready`.

## Structure
- Shared package `hsv_pkg`:
  - `SECTOR_W`=3.
  - Sector boundary constants 43/86/129/172/215.
  - `HUE_THIRD`=85.
  - Pixel triple typedef.
  - Also imported by `rgb2hsv` cleanup later.
- One sub-module, `mul8x8_hi`: registered 8×8 multiply returning bits [15:8]. Instantiated five times; this keeps the multiply timing identical across stages.
- The skid buffer is inline under the macro, not a separate module.

## Test plan
- h=0, s=255, v=255 → (255,0,0) 4 cycles after accept.
- h=85, s=255, v=255 → (3,255,0).
- h=170, s=255, v=255 → (0,9,255).
- s=0, v=128, h in {0, 100, 255} → (128,128,128) each, back-to-back, one per cycle.
- Stream 8 inputs with `out_ready` low for cycles 3–7:
  - No loss and no duplication; order preserved.
  - Outputs hold steady while stalled.
  - `in_ready` low during the stall (no skid); skid build keeps accepting until full.
- Assert `reset` low for one cycle with 3 items in flight:
  - `out_valid`=0 next cycle and `r,g,b`=0.
  - None of the 3 items ever emerges.
  - The next input emerges after nominal latency.
